// File: rtl/on_off_logic.sv
// Magnetron on/off request logic: registered set/reset requests plus a
// two-state cooking flag, all driven straight from flip-flops.
module on_off_logic (
    input  logic clk,
    input  logic rst,
    input  logic starn,
    input  logic stopn,
    input  logic clearn,
    input  logic door_closed,
    input  logic timer_done,
    output logic set,
    output logic reset,
    output logic on
);

    typedef enum logic {
        IDLE    = 1'b0,
        COOKING = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   off_c;
    logic   on_c;

    // Any off term vetoes start, so set and reset can never be requested together.
    always_comb begin
        off_c = !door_closed || !stopn || !clearn || timer_done;
        on_c  = !starn && door_closed && !timer_done && !off_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (on_c)  state_d = COOKING;
            COOKING: if (off_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            set     <= 1'b0;
            reset   <= 1'b0;
        end else begin
            state_q <= state_d;
            set     <= on_c;
            reset   <= off_c;
        end
    end

    assign on = (state_q == COOKING);

endmodule

// File: tb/tb_on_off_logic.sv
// Bench for on_off_logic: directed vector table followed by a randomised
// sweep checked against a small reference model through an expectation queue.
module tb_on_off_logic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic starn = 1'b1;
    logic stopn = 1'b1;
    logic clearn = 1'b1;
    logic door_closed = 1'b1;
    logic timer_done = 1'b0;
    logic set;
    logic reset;
    logic on;

    typedef struct {
        logic r;
        logic starn;
        logic stopn;
        logic clearn;
        logic door;
        logic timer;
        logic expSet;
        logic expReset;
        logic expOn;
    } vec_t;

    typedef struct {
        logic s;
        logic r;
        logic o;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[20];
    int   errors = 0;
    int   checks = 0;
    logic modelOn = 1'b0;

    on_off_logic dut (
        .clk(clk),
        .rst(rst),
        .starn(starn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .timer_done(timer_done),
        .set(set),
        .reset(reset),
        .on(on)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic st,
                                input logic c, input logic d, input logic t,
                                input logic es, input logic er, input logic eo);
        vec_t v;
        v.r = r; v.starn = s; v.stopn = st; v.clearn = c; v.door = d; v.timer = t;
        v.expSet = es; v.expReset = er; v.expOn = eo;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.r; starn = v.starn; stopn = v.stopn;
        clearn = v.clearn; door_closed = v.door; timer_done = v.timer;
        e.s = v.expSet; e.r = v.expReset; e.o = v.expOn;
        expQ.push_back(e);
    endtask

    task automatic compareBit(input string name, input int idx, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL queue step %0d: got empty expected entry", idx);
            return;
        end
        e = expQ.pop_front();
        compareBit("set", idx, set, e.s);
        compareBit("reset", idx, reset, e.r);
        compareBit("on", idx, on, e.o);
        compareBit("exclusive", idx, set & reset, 1'b0);
    endtask

    // Independent reference used for the random sweep.
    function automatic vec_t model(input logic r, input logic s, input logic st,
                                   input logic c, input logic d, input logic t);
        logic offC;
        logic onC;
        offC = !d || !st || !c || t;
        onC  = !s && d && !t && !offC;
        if (r) begin
            modelOn = 1'b0;
            return mk(r, s, st, c, d, t, 1'b0, 1'b0, 1'b0);
        end
        if (onC) modelOn = 1'b1;
        else if (offC) modelOn = 1'b0;
        return mk(r, s, st, c, d, t, onC, offC, modelOn);
    endfunction

    initial begin
        //            rst   starn stopn clearn door  timer set   reset on
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Start held through a timer expiry: set must stay low until timer clears.
        modelOn = 1'b0;
        applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        checkOutput(100);
        applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        checkOutput(101);
        applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        checkOutput(102);
        modelOn = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [5:0] r;
            r = 6'($urandom);
            applyStimulus(model(($urandom_range(0, 15) == 0), r[0], r[1] | r[4],
                                r[2] | r[5], r[3] | r[4], r[5] & r[0]));
            checkOutput(200 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/on_off_logic.md
ON_OFF_LOGIC -- requirements
Module: on_off_logic

Interface
REQ-001 The block SHALL have a single clock and synchronous active-high reset: clk input 1 (all state updates on rising edge); rst input 1 (synchronous, active-high).
REQ-002 The block SHALL provide ports, one per line (name  direction  width  meaning):
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- starn  input  1  start button, active-low (0 = pressed)
- stopn  input  1  stop button, active-low
- clearn  input  1  clear button, active-low
- door_closed  input  1  1 = door closed, 0 = door open
- timer_done  input  1  1 = cook timer expired
- set  output  1  registered request to turn magnetron on
- reset  output  1  registered request to turn magnetron off
- on  output  1  registered cooking-state flag
REQ-003 The block SHALL have no parameters.
REQ-004 All outputs SHALL be driven directly from flip-flops, with no combinational input-to-output path.

Function
REQ-005 The block SHALL compute the off condition as off_c = (door_closed==0) | (stopn==0) | (clearn==0) | (timer_done==1).
REQ-006 The block SHALL compute the on condition as on_c = (starn==0) & (door_closed==1) & (timer_done==0) & !off_c.
REQ-007 On each rising clk edge with rst=0, the block SHALL load reset <= off_c and set <= on_c, giving one-cycle latency from inputs to outputs.
REQ-008 set and reset SHALL never be 1 in the same cycle; off_c dominates when both conditions are met.
REQ-009 Both outputs SHALL be level-sensitive: set SHALL stay 1 for every cycle that on_c holds, and reset SHALL stay 1 for every cycle that off_c holds.
REQ-010 When neither condition holds (starn=1 and off_c=0), set and reset SHALL both be 0.
REQ-011 The on flag SHALL implement a two-state machine, IDLE (on=0) and COOKING (on=1).
REQ-012 The state machine SHALL go IDLE->COOKING on a cycle where on_c=1, COOKING->IDLE on a cycle where off_c=1, and otherwise hold its state.
REQ-013 on SHALL update on the same edge as set and reset, so on=1 in the cycle set first reads 1, and on=0 in the cycle reset first reads 1.
REQ-014 If the door is opened and then closed while starn is still held low, set SHALL reassert and on SHALL return to 1 one cycle after door_closed=1, provided no other off term is active.
REQ-015 If starn is held low while timer_done=1, set SHALL stay 0 until timer_done returns to 0.
REQ-016 The block SHALL NOT perform debouncing or edge detection; inputs are treated as synchronous to clk.

Reset
REQ-017 While rst=1 at a rising edge, the block SHALL force set=0, reset=0 and on=0 (IDLE), regardless of all other inputs.
REQ-018 rst SHALL have priority over every input condition, including rst asserted while COOKING.
REQ-019 After rst deasserts, the block SHALL evaluate inputs normally from the next rising edge.
REQ-020 Outputs SHALL be undefined only before the first rst edge; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-021 Start: starn=0, door_closed=1, stopn=1, clearn=1, timer_done=0 -> next edge: set=1, reset=0, on=1.
REQ-022 Door open/close: door_closed 1->0 with starn=0 -> next edge: set=0, reset=1, on=0; door_closed back to 1 -> next edge: set=1, reset=0, on=1.
REQ-023 Stop: stopn=0 with starn=0 -> next edge: set=0, reset=1, on=0; stopn=1 -> next edge: set=1, on=1.
REQ-024 Timer done: timer_done=1 with starn=0 while COOKING -> next edge: set=0, reset=1, on=0, held while timer_done=1.
REQ-025 Clear and idle: clearn=0 -> reset=1, on=0; all buttons released and door closed -> set=0, reset=0, on holds its value.
REQ-026 Reset mid-operation: rst=1 while COOKING with starn=0 -> next edge: set=0, reset=0, on=0; rst=0 -> following edge: set=1, on=1.
